// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// WbRegfile (module wb_regfile)
// Writeback-stage register file. It selects the writeback datum, commits it
// to the architectural registers, serves two combinational decode-stage reads
// and counts committed register writes.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   rst_n        : synchronous active-low reset (registers and counter)
//   WB_RegWrite  : writeback enable from MEM/WB
//   WB_MemtoReg  : writeback source, 1 = WB_memout, 0 = WB_ALUOut
//   WB_memout    : load data from MEM/WB
//   WB_ALUOut    : ALU result from MEM/WB
//   WB_RegRd     : destination register index
//   ID_Rs1/Rs2   : decode-stage read indices
//   ID_rd1/rd2   : read data for ID_Rs1 / ID_Rs2
//   WB_wd        : selected writeback datum (also used for EX forwarding)
//   WB_retired   : wrapping count of committed register writes
//
// Build option
//   WB_REGFILE_BYPASS_EN : when defined, a read of the register being written
//   in the same cycle returns the new datum instead of the stored value.
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            WB_RegWrite,
    input  logic            WB_MemtoReg,
    input  logic [XLEN-1:0] WB_memout,
    input  logic [XLEN-1:0] WB_ALUOut,
    input  logic [4:0]      WB_RegRd,
    input  logic [4:0]      ID_Rs1,
    input  logic [4:0]      ID_Rs2,
    output logic [XLEN-1:0] ID_rd1,
    output logic [XLEN-1:0] ID_rd2,
    output logic [XLEN-1:0] WB_wd,
    output logic [31:0]     WB_retired
);

    logic [XLEN-1:0] regs [NREG];
    logic [31:0]     retiredCount;
    logic            writeCommit;

    // Writeback datum is a plain mux; reset deliberately plays no part so
    // forwarding paths see the same value the register would receive.
    assign WB_wd = WB_MemtoReg ? WB_memout : WB_ALUOut;

    // A write only commits for a non-zero index that actually exists.
    assign writeCommit = WB_RegWrite && (WB_RegRd != 5'd0)
                         && (int'(WB_RegRd) < NREG);

    // Register array and retire counter share one clocked block so reset
    // naturally wins over a simultaneous write and its count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            retiredCount <= '0;
        end else if (writeCommit) begin
            regs[WB_RegRd] <= WB_wd;
            retiredCount   <= retiredCount + 32'd1;
        end
    end

    assign WB_retired = retiredCount;

    // Combinational read ports. Index 0 and out-of-range indices read zero.
    // With the bypass build, a same-cycle write to the indexed register is
    // forwarded so decode does not need to stall for that hazard.
    always_comb begin
        ID_rd1 = '0;
        ID_rd2 = '0;
        if (ID_Rs1 != 5'd0 && int'(ID_Rs1) < NREG) begin
            ID_rd1 = regs[ID_Rs1];
        end
        if (ID_Rs2 != 5'd0 && int'(ID_Rs2) < NREG) begin
            ID_rd2 = regs[ID_Rs2];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (writeCommit && rst_n && (WB_RegRd == ID_Rs1)) begin
            ID_rd1 = WB_wd;
        end
        if (writeCommit && rst_n && (WB_RegRd == ID_Rs2)) begin
            ID_rd2 = WB_wd;
        end
`else
        // Stored (pre-write) value is returned during the writing cycle.
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Directed self-checking bench for wb_regfile with hand-computed expectations.
// Honours WB_REGFILE_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic            clk;
    logic            rst_n;
    logic            WB_RegWrite;
    logic            WB_MemtoReg;
    logic [XLEN-1:0] WB_memout;
    logic [XLEN-1:0] WB_ALUOut;
    logic [4:0]      WB_RegRd;
    logic [4:0]      ID_Rs1;
    logic [4:0]      ID_Rs2;
    logic [XLEN-1:0] ID_rd1;
    logic [XLEN-1:0] ID_rd2;
    logic [XLEN-1:0] WB_wd;
    logic [31:0]     WB_retired;

    int checkCount = 0;
    int passCount  = 0;

    wb_regfile #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .WB_RegWrite (WB_RegWrite),
        .WB_MemtoReg (WB_MemtoReg),
        .WB_memout   (WB_memout),
        .WB_ALUOut   (WB_ALUOut),
        .WB_RegRd    (WB_RegRd),
        .ID_Rs1      (ID_Rs1),
        .ID_Rs2      (ID_Rs2),
        .ID_rd1      (ID_rd1),
        .ID_rd2      (ID_rd2),
        .WB_wd       (WB_wd),
        .WB_retired  (WB_retired)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive the writeback inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic we, input logic m2r,
                                 input logic [63:0] mem, input logic [63:0] alu,
                                 input logic [4:0] rd);
        WB_RegWrite = we;
        WB_MemtoReg = m2r;
        WB_memout   = mem;
        WB_ALUOut   = alu;
        WB_RegRd    = rd;
        #1;
    endtask

    // Advance one rising edge and sample 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readPorts(input logic [4:0] r1, input logic [4:0] r2);
        ID_Rs1 = r1;
        ID_Rs2 = r2;
        #1;
    endtask

    // Expected same-cycle read of a register being written (x7 case).
    logic [63:0] sameCycleExp;

    initial begin
`ifdef WB_REGFILE_BYPASS_EN
        sameCycleExp = 64'hAA;
`else
        sameCycleExp = 64'h55;
`endif
        rst_n = 1'b0;
        ID_Rs1 = 5'd0;
        ID_Rs2 = 5'd0;
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        tick();
        tick();

        // Reset state: every index reads zero on both ports, counter zero.
        for (int i = 0; i < NREG; i++) begin
            readPorts(5'(i), 5'(NREG - 1 - i));
            checkOutput("rstRd1", ID_rd1, 64'h0);
            checkOutput("rstRd2", ID_rd2, 64'h0);
        end
        checkOutput("rstRetired", {32'h0, WB_retired}, 64'h0);

        rst_n = 1'b1;
        #1;

        // Writeback mux, both selections.
        applyStimulus(1'b1, 1'b0, 64'hCAFE, 64'h1234, 5'd5);
        checkOutput("wdAlu", WB_wd, 64'h1234);
        applyStimulus(1'b1, 1'b1, 64'hCAFE, 64'h1234, 5'd5);
        checkOutput("wdMem", WB_wd, 64'hCAFE);

        // ALU write to x5.
        applyStimulus(1'b1, 1'b0, 64'hCAFE, 64'h1234, 5'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        readPorts(5'd5, 5'd5);
        checkOutput("x5Rd1", ID_rd1, 64'h1234);
        checkOutput("x5Rd2", ID_rd2, 64'h1234);
        checkOutput("retired1", {32'h0, WB_retired}, 64'd1);

        // Write to x0 is dropped and not counted.
        applyStimulus(1'b1, 1'b1, 64'hDEADBEEF, 64'h0, 5'd0);
        checkOutput("wdDead", WB_wd, 64'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        readPorts(5'd0, 5'd0);
        checkOutput("x0Rd1", ID_rd1, 64'h0);
        checkOutput("x0Rd2", ID_rd2, 64'h0);
        checkOutput("retiredX0", {32'h0, WB_retired}, 64'd1);

        // x7 = 0x55, then same-cycle write of 0xAA while reading x7.
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h55, 5'd7);
        tick();
        checkOutput("retired2", {32'h0, WB_retired}, 64'd2);
        readPorts(5'd7, 5'd7);
        applyStimulus(1'b1, 1'b1, 64'hAA, 64'h0, 5'd7);
        checkOutput("sameCycRd1", ID_rd1, sameCycleExp);
        checkOutput("sameCycRd2", ID_rd2, sameCycleExp);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        checkOutput("x7After", ID_rd2, 64'hAA);
        checkOutput("retired3", {32'h0, WB_retired}, 64'd3);

        // Disabled write leaves register and counter alone.
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h77, 5'd7);
        tick();
        checkOutput("x7Hold", ID_rd1, 64'hAA);
        checkOutput("retiredHold", {32'h0, WB_retired}, 64'd3);

        // Full-width datum to the top register, other port on x5.
        applyStimulus(1'b1, 1'b1, 64'hFEDC_BA98_7654_3210, 64'h0, 5'd31);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        readPorts(5'd31, 5'd5);
        checkOutput("x31Wide", ID_rd1, 64'hFEDC_BA98_7654_3210);
        checkOutput("x5Keep", ID_rd2, 64'h1234);
        checkOutput("retired4", {32'h0, WB_retired}, 64'd4);

        // Counter wrap: preload to all ones, then one more commit to x3.
        @(negedge clk);
        force dut.retiredCount = 32'hFFFF_FFFF;
        #1;
        release dut.retiredCount;
        #1;
        checkOutput("retiredPre", {32'h0, WB_retired}, 64'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h3, 5'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        readPorts(5'd3, 5'd7);
        checkOutput("retiredWrap", {32'h0, WB_retired}, 64'h0);
        checkOutput("x3Val", ID_rd1, 64'h3);

        // Reset during a write of 0x99 to x9: reset wins, nothing counted.
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h99, 5'd9);
        tick();
        checkOutput("retiredPreRst", {32'h0, WB_retired}, 64'd1);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h99, 5'd9);
        checkOutput("wdInRst", WB_wd, 64'h99);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        readPorts(5'd9, 5'd5);
        checkOutput("x9Rst", ID_rd1, 64'h0);
        checkOutput("x5Rst", ID_rd2, 64'h0);
        checkOutput("retiredRst", {32'h0, WB_retired}, 64'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width of every register and writeback datum.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers, addressed by 5 bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port WB_RegWrite, input, 1, writeback enable from the MEM/WB pipeline register.
REQ-006 SHALL have port WB_MemtoReg, input, 1, writeback source select: 1 = memory data, 0 = ALU result.
REQ-007 SHALL have port WB_memout, input, XLEN, load data from MEM/WB.
REQ-008 SHALL have port WB_ALUOut, input, XLEN, ALU result from MEM/WB.
REQ-009 SHALL have port WB_RegRd, input, 5, destination register index.
REQ-010 SHALL have ports ID_Rs1 and ID_Rs2, input, 5 each, decode-stage read indices.
REQ-011 SHALL have ports ID_rd1 and ID_rd2, output, XLEN each, read data for ID_Rs1 and ID_Rs2.
REQ-012 SHALL have port WB_wd, output, XLEN, selected writeback data, used by EX forwarding.
REQ-013 SHALL have port WB_retired, output, 32, count of committed register writes.

Function
REQ-014 SHALL drive WB_wd combinationally: WB_memout when WB_MemtoReg=1, otherwise WB_ALUOut.
REQ-015 SHALL write WB_wd into register WB_RegRd on the rising edge when WB_RegWrite=1 and WB_RegRd!=0.
REQ-016 SHALL ignore writes to register 0; register 0 SHALL always read as 0.
REQ-017 SHALL provide ID_rd1 and ID_rd2 as asynchronous (combinational) reads of the indexed registers.
REQ-018 SHALL allow ID_Rs1=ID_Rs2; both ports then return identical data.
REQ-019 SHALL increment WB_retired by 1 on each edge where a write commits under REQ-015.
REQ-020 SHALL leave WB_retired unchanged when WB_RegWrite=0 or when a write targets register 0.
REQ-021 SHALL wrap WB_retired from 0xFFFFFFFF to 0 with no flag or saturation.
REQ-022 SHALL have a write latency of one cycle: data written at edge N is visible on ID_rd* after edge N, except as modified by REQ-027.

Reset
REQ-023 SHALL clear all NREG registers to 0 on any rising edge with rst_n=0.
REQ-024 SHALL clear WB_retired to 0 on any rising edge with rst_n=0.
REQ-025 SHALL give reset priority over a simultaneous write; WB_RegWrite=1 during reset commits nothing and does not count.
REQ-026 SHALL keep WB_wd purely combinational and unaffected by rst_n.

Configuration
REQ-027 With macro WB_REGFILE_BYPASS_EN defined, SHALL return WB_wd on ID_rd1/ID_rd2 whenever WB_RegWrite=1, WB_RegRd!=0, rst_n=1 and WB_RegRd equals the read index (write-before-read in the same cycle).
REQ-028 Without WB_REGFILE_BYPASS_EN, SHALL return the stored (pre-write) register value during the writing cycle; the decode stage then relies on a hazard stall for that case.

Verification
REQ-029 Reset then read all indices -> ID_rd1=ID_rd2=0 for every index; WB_retired=0.
REQ-030 WB_RegWrite=1, WB_MemtoReg=0, WB_ALUOut=0x1234, WB_RegRd=5, one edge; then ID_Rs1=5 -> ID_rd1=0x1234, WB_retired=1.
REQ-031 WB_RegWrite=1, WB_MemtoReg=1, WB_memout=0xDEADBEEF, WB_RegRd=0 -> register 0 reads 0; WB_retired unchanged.
REQ-032 Same-cycle write of 0xAA to x7 with ID_Rs2=7, register holding 0x55 -> ID_rd2=0xAA with WB_REGFILE_BYPASS_EN, 0x55 without; 0xAA in both builds after the edge.
REQ-033 WB_retired preloaded via 0xFFFFFFFF commits, one further commit to x3 -> WB_retired=0.
REQ-034 rst_n=0 asserted in the same cycle as a write of 0x99 to x9 -> x9 reads 0 and WB_retired=0 after the edge.
